// File: rtl/dec3to8_pkg.sv
// Shared types and constants for the decoder3to8_hold block.
// Output polarity is selected by DEC3TO8_ACTIVE_LOW_EN (undefined: active-high one-hot).
package dec3to8_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned OUT_W  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StGap
  } state_e;

`ifdef DEC3TO8_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] OUT_IDLE = 8'hFF;
`else
  localparam logic [OUT_W-1:0] OUT_IDLE = 8'h00;
`endif

  // Maps an active-high one-hot pattern onto the configured output polarity.
  function automatic logic [OUT_W-1:0] drive_level(input logic [OUT_W-1:0] onehot);
`ifdef DEC3TO8_ACTIVE_LOW_EN
    return ~onehot;
`else
    return onehot;
`endif
  endfunction

endpackage

// File: rtl/onehot_dec3to8.sv
// Purely combinational 3-to-8 one-hot decode (active-high).
module onehot_dec3to8
  import dec3to8_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [OUT_W-1:0]  o_onehot
);

  always_comb begin
    o_onehot         = '0;
    o_onehot[i_code] = 1'b1;
  end

endmodule

// File: rtl/decoder3to8_hold.sv
// Sequential 3-to-8 decoder: holds the selected line HOLD_CYCLES cycles, then one break cycle.
// Output polarity follows DEC3TO8_ACTIVE_LOW_EN (see dec3to8_pkg).
module decoder3to8_hold
  import dec3to8_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  output logic              code_ready,
  output logic [OUT_W-1:0]  Y,
  output logic              busy,
  output logic              done
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [OUT_W-1:0]   r_y;
  logic [OUT_W-1:0]   w_y_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic [OUT_W-1:0]   w_onehot;

  onehot_dec3to8 u_onehot (
    .i_code   (code),
    .o_onehot (w_onehot)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_y_nxt     = r_y;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_y_nxt = OUT_IDLE;
        if (code_valid && en) begin
          // Polarity applied before the register so Y never glitches.
          w_y_nxt     = drive_level(w_onehot);
          w_cnt_nxt   = CNT_W'(HOLD_CYCLES - 1);
          w_state_nxt = StHold;
        end
      end
      StHold: begin
        // Abort wins over normal completion on the same edge.
        if (!en) begin
          w_y_nxt     = OUT_IDLE;
          w_cnt_nxt   = '0;
          w_state_nxt = StGap;
        end else if (r_cnt == '0) begin
          w_y_nxt     = OUT_IDLE;
          w_done_nxt  = 1'b1;
          w_state_nxt = StGap;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      StGap: begin
        w_y_nxt     = OUT_IDLE;
        w_state_nxt = StIdle;
      end
      default: begin
        w_y_nxt     = OUT_IDLE;
        w_cnt_nxt   = '0;
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_y     <= OUT_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_y     <= w_y_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign code_ready = en && (r_state == StIdle);
  assign busy       = (r_state != StIdle);
  assign Y          = r_y;
  assign done       = r_done;

endmodule

// File: tb/tb_decoder3to8_hold.sv
// Bench for decoder3to8_hold: two instances (HOLD_CYCLES 4 and 1) against a timeline model.
// Honours DEC3TO8_ACTIVE_LOW_EN for the expected output polarity.
module tb_decoder3to8_hold;

`ifdef DEC3TO8_ACTIVE_LOW_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif
  localparam logic [7:0] YOFF = INV ? 8'hFF : 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       code_valid = 1'b0;
  logic [2:0] code = 3'd0;

  logic [7:0] dut_y     [2];
  logic       dut_ready [2];
  logic       dut_busy  [2];
  logic       dut_done  [2];

  int n_cmp  = 0;
  int n_fail = 0;

  // Timeline model: edge of acceptance, edge where the hold ends, and how it ended.
  int         hold_len [2] = '{4, 1};
  int         m_acc    [2];
  int         m_end    [2];
  bit         m_known  [2];
  bit         m_norm   [2];
  logic [2:0] m_code   [2];
  int         n = 0;

  always #5 clk = ~clk;

  decoder3to8_hold #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .code_valid (code_valid),
    .code       (code),
    .code_ready (dut_ready[0]),
    .Y          (dut_y[0]),
    .busy       (dut_busy[0]),
    .done       (dut_done[0])
  );

  decoder3to8_hold #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .code_valid (code_valid),
    .code       (code),
    .code_ready (dut_ready[1]),
    .Y          (dut_y[1]),
    .busy       (dut_busy[1]),
    .done       (dut_done[1])
  );

  function automatic bit is_idle(int i, int e);
    return (m_acc[i] < 0) || (m_known[i] && e >= m_end[i] + 1);
  endfunction

  function automatic bit in_hold(int i);
    return !is_idle(i, n) && (!m_known[i] || n < m_end[i]);
  endfunction

  function automatic bit in_gap(int i);
    return !is_idle(i, n) && m_known[i] && n == m_end[i];
  endfunction

  function automatic logic [7:0] exp_y(int i);
    logic [7:0] oh;
    oh = 8'd1 << m_code[i];
    if (in_hold(i)) return INV ? ~oh : oh;
    return YOFF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i]   = -1;
      m_end[i]   = 0;
      m_known[i] = 1'b0;
      m_norm[i]  = 1'b0;
      m_code[i]  = 3'd0;
    end
  endtask

  // Called once per rising edge with the inputs that were stable at that edge.
  task automatic model_edge();
    n++;
    if (!rst_n) return;
    for (int i = 0; i < 2; i++) begin
      if (m_acc[i] < 0 || (m_known[i] && n >= m_end[i] + 2)) begin
        if (en && code_valid) begin
          m_acc[i]   = n;
          m_code[i]  = code;
          m_known[i] = 1'b0;
          m_norm[i]  = 1'b0;
        end
      end else if (!m_known[i]) begin
        if (!en) begin
          m_end[i]   = n;
          m_norm[i]  = 1'b0;
          m_known[i] = 1'b1;
        end else if (n == m_acc[i] + hold_len[i]) begin
          m_end[i]   = n;
          m_norm[i]  = 1'b1;
          m_known[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s @edge %0d: observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.d%0d.Y", tag, i), dut_y[i], exp_y(i));
      chk($sformatf("%s.d%0d.ready", tag, i), {7'd0, dut_ready[i]},
          {7'd0, en && is_idle(i, n)});
      chk($sformatf("%s.d%0d.busy", tag, i), {7'd0, dut_busy[i]}, {7'd0, !is_idle(i, n)});
      chk($sformatf("%s.d%0d.done", tag, i), {7'd0, dut_done[i]},
          {7'd0, in_gap(i) && m_norm[i]});
    end
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int k;
    model_reset();
    en = 1'b1;
    #1 check_all("reset");
    tick("reset");
    tick("reset");
    rst_n = 1'b1;
    check_all("post_reset");

    // Single code 5 on both instances.
    code = 3'd5; code_valid = 1'b1;
    tick("single");
    code_valid = 1'b0;
    repeat (8) tick("single");

    // Code 7 (HOLD_CYCLES=1 instance gives a one-cycle pulse).
    code = 3'd7; code_valid = 1'b1;
    tick("code7");
    code_valid = 1'b0;
    repeat (7) tick("code7");

    // Back-to-back sweep, code advances whenever instance 0 accepts.
    k = 0; code = 3'd0; code_valid = 1'b1;
    for (int t = 0; t < 60 && k < 8; t++) begin
      tick("sweep");
      if (m_acc[0] == n) begin
        k++;
        code = 3'(k);
      end
    end
    code_valid = 1'b0;
    chk("sweep_count", 8'(k), 8'd8);
    repeat (6) tick("sweep_tail");

    // Abort in the 2nd hold cycle of code 3.
    code = 3'd3; code_valid = 1'b1;
    tick("abort");
    code_valid = 1'b0;
    tick("abort");
    en = 1'b0;
    check_all("abort_en_low");
    repeat (3) tick("abort");
    en = 1'b1;
    repeat (3) tick("abort");

    // Randomized traffic.
    for (int t = 0; t < 400; t++) begin
      en         = ($urandom_range(0, 9) != 0);
      code_valid = ($urandom_range(0, 2) != 0);
      code       = 3'($urandom);
      tick("rand");
    end
    en = 1'b1; code_valid = 1'b0;
    repeat (6) tick("drain");

    // Asynchronous reset in the middle of a code-5 hold.
    code = 3'd5; code_valid = 1'b1;
    tick("rst_setup");
    code_valid = 1'b0;
    tick("rst_setup");
    chk("pre_rst.Y", dut_y[0], INV ? 8'hDF : 8'h20);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    tick("in_rst");
    rst_n = 1'b1;
    check_all("rst_release");
    repeat (3) tick("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
